// File: rtl/sysid_check_master.sv
// sysid_check_master: reads sysid ID and timestamp words over Avalon-MM and checks them; SYSID_CHECK_AUTOSTART_EN adds a post-reset auto launch
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    typedef enum logic [2:0] {IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, FIN} state_t;
    localparam logic [1:0]  LAT_LAST   = 2'(READ_LATENCY == 0 ? 0 : READ_LATENCY - 1);
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t      state, state_nx;
    logic [15:0] stall_cnt;
    logic [1:0]  lat_cnt;
    logic        go, req, lat, accept, stall_hit, lat_done, take_id, take_ts;
`ifdef SYSID_CHECK_AUTOSTART_EN
    logic armed;
    // One-shot that behaves like a start pulse on the first edge after reset
    always_ff @(posedge clock or posedge reset)
        if (reset) armed <= 1'b1;
        else       armed <= 1'b0;
    assign go = start | armed;
`else
    assign go = start;
`endif
    assign req       = state == REQ_ID || state == REQ_TS;
    assign lat       = state == LAT_ID || state == LAT_TS;
    assign accept    = req && !avm_waitrequest;
    assign stall_hit = req && avm_waitrequest && stall_cnt == STALL_LAST;
    assign lat_done  = lat && lat_cnt == LAT_LAST;
    assign take_id   = READ_LATENCY == 0 ? state == REQ_ID && accept : state == LAT_ID && lat_done;
    assign take_ts   = READ_LATENCY == 0 ? state == REQ_TS && accept : state == LAT_TS && lat_done;
    // State register
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;
    // Next state: a stall timeout abandons the rest of the sequence
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = REQ_ID;
            REQ_ID:  if (stall_hit) state_nx = FIN;
                     else if (accept) state_nx = READ_LATENCY == 0 ? REQ_TS : LAT_ID;
            LAT_ID:  if (lat_done) state_nx = REQ_TS;
            REQ_TS:  if (stall_hit) state_nx = FIN;
                     else if (accept) state_nx = READ_LATENCY == 0 ? FIN : LAT_TS;
            LAT_TS:  if (lat_done) state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end
    // Bus and handshake outputs decoded from state only
    always_comb begin
        avm_read    = req;
        avm_address = state == REQ_TS;
        done        = state == FIN;
    end
    // Counters, status flags and captured words
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            stall_cnt <= 16'd0;
            lat_cnt   <= 2'd0;
            busy      <= 1'b0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= 32'd0;
            ts_value  <= 32'd0;
        end else begin
            stall_cnt <= (req && avm_waitrequest && !stall_hit) ? stall_cnt + 16'd1 : 16'd0;
            lat_cnt   <= (lat && !lat_done) ? lat_cnt + 2'd1 : 2'd0;
            if (state == IDLE && go) begin
                busy    <= 1'b1;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (state == FIN) busy <= 1'b0;
            if (stall_hit) timeout <= 1'b1;
            if (take_id) begin
                id_value <= avm_readdata;
                id_ok    <= avm_readdata == EXPECTED_ID;
            end
            if (take_ts) begin
                ts_value <= avm_readdata;
                ts_ok    <= avm_readdata == EXPECTED_TS;
            end
        end
endmodule

// File: tb/tb_sysid_check_master.sv
// tb_sysid_check_master: randomized scoreboard bench for sysid_check_master
module tb_sysid_check_master;
    localparam logic [31:0] EID = 32'h5A42_10FE;
    localparam logic [31:0] ETS = 32'h0000_1234;
    localparam int LAT = 2;
    localparam int TO  = 8;

    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic        avm_address, avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    sysid_check_master #(
        .EXPECTED_ID(EID), .EXPECTED_TS(ETS), .READ_LATENCY(LAT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
        .id_value(id_value), .ts_value(ts_value)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        idok, tsok, to;
        logic [31:0] idv, tsv;
        int          dcyc, rd, rd1;
    } exp_t;
    exp_t sbq[$];

    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] w_id = 32'd0, w_ts = 32'd0;
    int st_id = 0, st_ts = 0;
    logic [31:0] m_id = 32'd0, m_ts = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Slave: stall counter per request, read data delivered LAT cycles after acceptance
    int   sc = 0;
    logic hold = 1'b0;
    logic [31:0] pd [4];
    logic        pv [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    always @(posedge clock) begin
        for (int i = 1; i < 4; i++) begin
            pd[i] <= pd[i-1];
            pv[i] <= pv[i-1];
        end
        pv[0] <= avm_read && !avm_waitrequest;
        pd[0] <= avm_address ? w_ts : w_id;
        sc    <= (avm_read && avm_waitrequest) ? sc + 1 : 0;
        hold  <= avm_read && avm_waitrequest && (sc < TO - 1);
    end
    always @(negedge clock) begin
        avm_waitrequest <= avm_read && (sc < (avm_address ? st_ts : st_id));
        avm_readdata    <= pv[LAT-1] ? pd[LAT-1] : $urandom;
    end

    // Expected outcome of one sequence from stall counts and returned words
    task automatic push_exp(input int s);
        exp_t e;
        e.tsv = m_ts;
        if (st_id >= TO) begin
            e.dcyc = s + 1 + TO; e.rd = TO; e.rd1 = 0;
            e.idok = 1'b0; e.tsok = 1'b0; e.to = 1'b1; e.idv = m_id;
        end else begin
            m_id = w_id; e.idv = w_id; e.idok = (w_id == EID);
            if (st_ts >= TO) begin
                e.dcyc = s + 1 + st_id + 1 + LAT + TO; e.rd = st_id + 1 + TO; e.rd1 = TO;
                e.tsok = 1'b0; e.to = 1'b1;
            end else begin
                e.dcyc = s + st_id + st_ts + 2 * LAT + 3; e.rd = st_id + st_ts + 2; e.rd1 = st_ts + 1;
                m_ts = w_ts; e.tsv = w_ts; e.tsok = (w_ts == ETS); e.to = 1'b0;
            end
        end
        sbq.push_back(e);
    endtask

    // Monitor: pops and compares whenever done is presented
    int rd = 0, rd1 = 0;
    initial forever begin
        @(negedge clock);
        if (reset) begin
            rd = 0; rd1 = 0;
        end else begin
            if (hold) chk("hold_stable", {avm_read, avm_address}, {1'b1, avm_address});
            if (avm_read) begin
                rd++;
                if (avm_address) rd1++;
            end
            if (done) begin
                if (sbq.size() == 0) chk("spurious_done", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.dcyc);
                    chk("flags", {id_ok, ts_ok, timeout}, {e.idok, e.tsok, e.to});
                    chk("id_value", id_value, e.idv);
                    chk("ts_value", ts_value, e.tsv);
                    chk("read_cycles", rd, e.rd);
                    chk("addr1_cycles", rd1, e.rd1);
                    chk("busy_at_done", busy, 1'b1);
                end
                rd = 0; rd1 = 0;
            end
        end
    end

    task automatic release_reset();
        reset = 1'b0;
`ifdef SYSID_CHECK_AUTOSTART_EN
        push_exp(cyc);
        wait_idle();
`endif
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clock);
        if (sbq.size() != 0) begin
            chk("done_wait", 32'd0, 32'd1);
            sbq.delete();
        end
        repeat (2) @(negedge clock);
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic run(input logic [31:0] wid, input logic [31:0] wts, input int sid, input int sts, input bit mid);
        w_id = wid; w_ts = wts; st_id = sid; st_ts = sts;
        start = 1'b1;
        push_exp(cyc);
        @(negedge clock);
        start = 1'b0;
        if (mid) begin
            repeat (2) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {25'd0, busy, done, id_ok, ts_ok, timeout, avm_read, avm_address}, 32'd0);
        chk({nm, "_id"}, id_value, 32'd0);
        chk({nm, "_ts"}, ts_value, 32'd0);
    endtask

    initial begin
        int s;
        #12;
        chk_zero("reset_outs");
        @(negedge clock);
        release_reset();
        repeat (2) @(negedge clock);
        run(EID, ETS, 0, 0, 0);
        run(32'hDEAD_BEEF, ETS, 0, 0, 0);
        run(EID, ETS, 1000, 0, 0);
        run(EID, ETS, 3, 0, 1);
        run(EID, 32'h0BAD_0001, 1, 1000, 0);
        run(EID, ETS, TO - 1, TO - 1, 1);
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a, b;
            int x, y;
            a = ($urandom_range(0, 1) == 0) ? EID : $urandom;
            b = ($urandom_range(0, 1) == 0) ? ETS : $urandom;
            x = ($urandom_range(0, 4) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 4);
            y = ($urandom_range(0, 4) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 4);
            run(a, b, x, y, $urandom_range(0, 1) == 1);
        end
        w_id = EID; w_ts = ETS; st_id = 0; st_ts = 0;
        start = 1'b1;
        s = cyc;
        @(negedge clock);
        start = 1'b0;
        while (cyc < s + 5) @(negedge clock);
        chk("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk_zero("midseq_reset");
        m_id = 32'd0; m_ts = 32'd0;
        @(negedge clock);
        chk_zero("held_reset");
        release_reset();
        repeat (2) @(negedge clock);
        run(EID, ETS, 2, 1, 0);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1);
    end
endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read master that drives the 1-bit-address, 32-bit system-ID control slave.
- It reads word 0 (system ID) and word 1 (build timestamp), latches both, and compares them against expected values.
- Flags match, mismatch and timeout so boot logic or an LED status path can gate startup on the expected hardware image.
- Sits in the Qsys system beside the sysid slave on the same interconnect.

Parameters:
- EXPECTED_ID, 32'h0000_0000, value word 0 must equal for id_ok.
- EXPECTED_TS, 32'h0000_0000, value word 1 must equal for ts_ok.
- READ_LATENCY, 0, fixed slave read latency in cycles, legal range 0..3.
- TIMEOUT_CYCLES, 1023, max consecutive waitrequest-stalled cycles per read, legal range 1..65535.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a check sequence; ignored while busy.
- avm_address  out  1  0 = ID word, 1 = timestamp word.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall; tie 0 if the slave has none.
- avm_readdata  in  32  read data.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at sequence end.
- id_ok  out  1  latched: ID read matched EXPECTED_ID.
- ts_ok  out  1  latched: timestamp read matched EXPECTED_TS.
- timeout  out  1  latched: a read stalled TIMEOUT_CYCLES cycles.
- id_value  out  32  last captured word 0.
- ts_value  out  32  last captured word 1.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, FSM in IDLE, stall counter 0, latency counter 0.
- FSM states: IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, FIN.
- IDLE:
  - start=1 -> REQ_ID.
  - Same edge: busy<=1; id_ok, ts_ok, timeout cleared.
  - id_value and ts_value retain their old contents until overwritten.
- REQ_ID:
  - avm_read=1, avm_address=0, held stable while avm_waitrequest=1.
  - Accepted on the cycle avm_read=1 and avm_waitrequest=0.
- LAT_ID:
  - Wait READ_LATENCY cycles after acceptance, then sample avm_readdata into id_value.
  - id_ok<=(avm_readdata==EXPECTED_ID), then go to REQ_TS.
  - READ_LATENCY=0: sample on the accept cycle itself and go directly REQ_ID -> REQ_TS; LAT_ID is skipped.
- REQ_TS / LAT_TS: identical to REQ_ID / LAT_ID with avm_address=1, ts_value and ts_ok.
- FIN:
  - Lasts one cycle: done=1, busy<=0, then IDLE.
  - First accepted start in IDLE starts the next sequence.
- avm_read is 0 in all states except REQ_*. Exactly one read is issued per REQ_* state; no pipelined overlap.
- Stall counter (16 bit):
  - Increments each REQ_* cycle with avm_waitrequest=1; clears on acceptance and on entering REQ_*.
  - On reaching TIMEOUT_CYCLES: deassert avm_read, set timeout=1, jump to FIN.
  - The pending word's value and ok flag are not updated, and the remaining read is skipped.
- Read data on cycles other than the sample cycle is ignored.
- start while busy is ignored. It is not queued.
- Mid-sequence reset: avm_read drops asynchronously, and all flags and values clear.

Optional Feature:
- Macro: SYSID_CHECK_AUTOSTART_EN.
- Defined: an internal one-shot launches a sequence on the first clock edge after reset deasserts, as if start were pulsed; start still works afterwards.
- Undefined: a sequence begins only on an external start pulse.

Test Plan:
- Slave model returns 32'h5A42_10FE/32'h0000_1234, waitrequest=0, EXPECTED_ID/TS matching, READ_LATENCY=0; pulse start:
  - reads at address 0 then 1 on consecutive cycles;
  - done pulses on the 3rd cycle after start;
  - id_ok=1, ts_ok=1, timeout=0.
- READ_LATENCY=2, slave data delayed 2 cycles:
  - captured values are correct;
  - avm_read is high exactly 2 cycles total;
  - done occurs 7 cycles after start.
- Slave ID returns 32'hDEAD_BEEF against EXPECTED_ID=32'h5A42_10FE: id_ok=0, id_value=32'hDEAD_BEEF, ts_ok=1, done pulses.
- waitrequest held high forever, TIMEOUT_CYCLES=8:
  - avm_read is high 8 cycles then drops;
  - timeout=1, done pulses, address 1 is never read.
- waitrequest high 3 cycles on the ID read:
  - address and read are held stable;
  - completes with id_ok=1, timeout=0;
  - a start pulse issued mid-sequence is ignored, so there is only one done.
- Reset asserted during LAT_TS then released: all outputs 0. With SYSID_CHECK_AUTOSTART_EN, a new sequence begins automatically and busy=1 on the first edge after release.
